// File: rtl/router_olck_arbiter_pkg.sv
// Shared router slice definitions: arbiter state encoding and counter width helpers.
package router_olck_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } olck_state_e;

    function automatic int unsigned credit_cnt_width(input int unsigned credit_max);
        return 32'($clog2(credit_max + 1));
    endfunction

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Round-robin one-hot pick: first set request strictly after ptr, wrapping around.
module router_rr_pick
    import router_olck_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]            req,
    input  logic [sel_width(N)-1:0] ptr,
    output logic [N-1:0]            gnt
);

    localparam int unsigned PW = sel_width(N);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            logic [PW-1:0] idx;
            idx = PW'((32'(ptr) + off) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_olck_arbiter.sv
// Output-link lock arbiter: grants one head flit round-robin, holds the lock until
// the tail transfers, and gates transfers on downstream credits.
module router_olck_arbiter
    import router_olck_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned CREDIT_MAX = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_IN-1:0]                       in_valid,
    input  logic [NUM_IN-1:0]                       in_head,
    input  logic [NUM_IN-1:0]                       in_tail,
    output logic [NUM_IN-1:0]                       in_ready,
    input  logic                                    credit_return,
    output logic                                    out_valid,
    output logic [sel_width(NUM_IN)-1:0]            out_sel,
    output logic [NUM_IN-1:0]                       olck_q,
    output logic [credit_cnt_width(CREDIT_MAX)-1:0] credit_cnt,
    output logic                                    credit_err
);

    localparam int unsigned SEL_W = sel_width(NUM_IN);
    localparam int unsigned CNT_W = credit_cnt_width(CREDIT_MAX);

    olck_state_e       state_q, state_d;
    logic [NUM_IN-1:0] olck_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
    logic              credit_err_q, credit_err_d;

    logic [NUM_IN-1:0] head_req;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              credit_ok;
    logic              xfer;
    logic              tail_xfer;

    assign head_req  = in_valid & in_head;
    assign credit_ok = (credit_cnt_q != '0);
    assign in_ready  = (state_q == ST_LOCKED && credit_ok) ? olck_q : '0;
    assign xfer      = |(in_valid & in_ready);
    assign tail_xfer = |(in_valid & in_ready & in_tail);

    assign out_valid  = xfer;
    assign out_sel    = out_sel_q;
    assign credit_cnt = credit_cnt_q;
    assign credit_err = credit_err_q;

    router_rr_pick #(
        .N (NUM_IN)
    ) u_rr_pick (
        .req (head_req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) gnt_idx = SEL_W'(i);
        end
    end

    // Lock FSM; ptr remembers the last released input so it has lowest priority next.
    always_comb begin
        state_d   = state_q;
        olck_d    = olck_q;
        ptr_d     = ptr_q;
        out_sel_d = out_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (credit_ok && |head_req) begin
                    state_d   = ST_LOCKED;
                    olck_d    = gnt;
                    out_sel_d = gnt_idx;
                end
            end
            ST_LOCKED: begin
                if (tail_xfer) begin
                    state_d = ST_IDLE;
                    olck_d  = '0;
                    ptr_d   = out_sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                olck_d  = '0;
            end
        endcase
    end

    // Credit counter saturates at CREDIT_MAX and flags the overflow stickily.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        case ({xfer, credit_return})
            2'b10: credit_cnt_d = credit_cnt_q - CNT_W'(1);
            2'b01: begin
                if (credit_cnt_q == CNT_W'(CREDIT_MAX)) credit_err_d = 1'b1;
                else                                     credit_cnt_d = credit_cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            olck_q       <= '0;
            ptr_q        <= SEL_W'(NUM_IN - 1);
            out_sel_q    <= '0;
            credit_cnt_q <= CNT_W'(CREDIT_MAX);
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            olck_q       <= olck_d;
            ptr_q        <= ptr_d;
            out_sel_q    <= out_sel_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_router_olck_arbiter.sv
// Directed bench for router_olck_arbiter with hand-computed expectations.
module tb_router_olck_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] in_valid, in_head, in_tail, in_ready, olck_q;
    logic       credit_return, out_valid, credit_err;
    logic [1:0] out_sel;
    logic [2:0] credit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    router_olck_arbiter #(
        .NUM_IN     (4),
        .CREDIT_MAX (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_head       (in_head),
        .in_tail       (in_tail),
        .in_ready      (in_ready),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_sel       (out_sel),
        .olck_q        (olck_q),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t);
        in_valid = v;
        in_head  = h;
        in_tail  = t;
    endtask

    initial begin
        reset = 1'b0;
        credit_return = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_olck",    32'(olck_q),     32'h0);
        check_eq("rst_cnt",     32'(credit_cnt), 32'd4);
        check_eq("rst_err",     32'(credit_err), 32'd0);
        check_eq("rst_sel",     32'(out_sel),    32'd0);
        check_eq("rst_ready",   32'(in_ready),   32'h0);
        check_eq("rst_ovalid",  32'(out_valid),  32'd0);
        reset = 1'b1;

        // Heads on 0 and 2; 0 wins first and is a single-flit packet
        drive(4'b0101, 4'b0101, 4'b0001);
        #1;
        check_eq("idle_ready",  32'(in_ready),   32'h0);
        check_eq("idle_olck",   32'(olck_q),     32'h0);
        tick();
        check_eq("g0_olck",     32'(olck_q),     32'h1);
        check_eq("g0_sel",      32'(out_sel),    32'd0);
        check_eq("g0_ready",    32'(in_ready),   32'h1);
        check_eq("g0_ovalid",   32'(out_valid),  32'd1);
        tick();
        drive(4'b0100, 4'b0100, 4'b0100);
        #1;
        check_eq("rel0_olck",   32'(olck_q),     32'h0);
        check_eq("rel0_ovalid", 32'(out_valid),  32'd0);
        check_eq("rel0_cnt",    32'(credit_cnt), 32'd3);
        tick();
        check_eq("g2_olck",     32'(olck_q),     32'h4);
        check_eq("g2_sel",      32'(out_sel),    32'd2);
        check_eq("g2_ovalid",   32'(out_valid),  32'd1);
        tick();
        drive(4'b0000, 4'b0000, 4'b0000);
        #1;
        check_eq("rel2_olck",   32'(olck_q),     32'h0);
        check_eq("rel2_cnt",    32'(credit_cnt), 32'd2);
        check_eq("rel2_sel",    32'(out_sel),    32'd2);

        // Refill to 4, then one extra return overflows
        credit_return = 1'b1;
        tick();
        tick();
        check_eq("refill_cnt",  32'(credit_cnt), 32'd4);
        check_eq("refill_err",  32'(credit_err), 32'd0);
        tick();
        check_eq("ovf_cnt",     32'(credit_cnt), 32'd4);
        check_eq("ovf_err",     32'(credit_err), 32'd1);
        credit_return = 1'b0;
        tick();
        tick();
        check_eq("ovf_sticky",  32'(credit_err), 32'd1);

        // Input 1 locked (ptr=2 -> search 3,0,1), drains all four credits
        drive(4'b0010, 4'b0010, 4'b0000);
        tick();
        check_eq("g1_olck",     32'(olck_q),     32'h2);
        check_eq("g1_sel",      32'(out_sel),    32'd1);
        drive(4'b0010, 4'b0000, 4'b0000);
        #1;
        check_eq("g1_ready",    32'(in_ready),   32'h2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("drain_cnt", 32'(credit_cnt), 32'(3 - k));
        end
        check_eq("dry_ready",   32'(in_ready),   32'h0);
        check_eq("dry_ovalid",  32'(out_valid),  32'd0);
        tick();
        check_eq("dry_cnt",     32'(credit_cnt), 32'd0);
        check_eq("dry_olck",    32'(olck_q),     32'h2);
        credit_return = 1'b1;
        #1;
        check_eq("cr_ready",    32'(in_ready),   32'h0);
        tick();
        credit_return = 1'b0;
        #1;
        check_eq("one_cnt",     32'(credit_cnt), 32'd1);
        check_eq("one_ready",   32'(in_ready),   32'h2);
        check_eq("one_ovalid",  32'(out_valid),  32'd1);
        tick();
        check_eq("one_used",    32'(credit_cnt), 32'd0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        check_eq("drop_olck",   32'(olck_q),     32'h2);
        check_eq("drop_cnt",    32'(credit_cnt), 32'd1);

        // Asynchronous reset mid-packet with one credit left
        drive(4'b0010, 4'b0000, 4'b0000);
        #1;
        check_eq("pre_rst_rdy", 32'(in_ready),   32'h2);
        reset = 1'b0;
        #1;
        check_eq("arst_olck",   32'(olck_q),     32'h0);
        check_eq("arst_cnt",    32'(credit_cnt), 32'd4);
        check_eq("arst_ready",  32'(in_ready),   32'h0);
        check_eq("arst_err",    32'(credit_err), 32'd0);
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;

        // Input 3 valid without head: no grant
        drive(4'b1000, 4'b0000, 4'b0000);
        tick();
        tick();
        check_eq("nohead_olck", 32'(olck_q),     32'h0);
        drive(4'b1000, 4'b1000, 4'b0000);
        tick();
        check_eq("g3_olck",     32'(olck_q),     32'h8);
        check_eq("g3_sel",      32'(out_sel),    32'd3);
        drive(4'b1000, 4'b0000, 4'b0000);
        tick();
        tick();
        check_eq("g3_cnt2",     32'(credit_cnt), 32'd2);
        credit_return = 1'b1;
        #1;
        check_eq("both_ovalid", 32'(out_valid),  32'd1);
        tick();
        check_eq("both_cnt",    32'(credit_cnt), 32'd2);
        credit_return = 1'b0;
        drive(4'b1000, 4'b0000, 4'b1000);
        tick();
        check_eq("rel3_olck",   32'(olck_q),     32'h0);
        check_eq("rel3_cnt",    32'(credit_cnt), 32'd1);

        // ptr=3 wraps so input 0 beats input 3
        drive(4'b1001, 4'b1001, 4'b0000);
        tick();
        check_eq("wrap_olck",   32'(olck_q),     32'h1);
        check_eq("wrap_sel",    32'(out_sel),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_olck_arbiter.md
ROUTER_OLCK_ARBITER -- requirements
Module: router_olck_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of input ports competing for one output link.
REQ-002 Parameter CREDIT_MAX, default 4, downstream buffer depth in flits; counter width is clog2(CREDIT_MAX+1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  NUM_IN  per-input flit valid.
REQ-006 in_head  input  NUM_IN  per-input head-flit marker, qualified by in_valid.
REQ-007 in_tail  input  NUM_IN  per-input tail-flit marker, qualified by in_valid; head and tail may both be set for a single-flit packet.
REQ-008 in_ready  output  NUM_IN  per-input accept; a transfer occurs when in_valid and in_ready are both high.
REQ-009 credit_return  input  1  one downstream buffer slot freed this cycle.
REQ-010 out_valid  output  1  a flit crosses the output link this cycle.
REQ-011 out_sel  output  clog2(NUM_IN)  index of the input driving the output mux.
REQ-012 olck_q  output  NUM_IN  registered one-hot output-lock vector; drives the output-lock flip-flops of the slice.
REQ-013 credit_cnt  output  clog2(CREDIT_MAX+1)  current available credits.
REQ-014 credit_err  output  1  sticky credit-overflow flag.

Function
REQ-015 Two states: IDLE (olck_q all zero) and LOCKED (olck_q one-hot).
REQ-016 In IDLE, when credit_cnt > 0 and any input has in_valid and in_head, the block SHALL grant exactly one such input round-robin, searching from index ptr+1 upward with wrap-around.
REQ-017 The grant SHALL be registered: olck_q becomes one-hot and the state becomes LOCKED on the edge after the request; in_ready is zero for all inputs while IDLE.
REQ-018 Requests without in_head SHALL never win arbitration.
REQ-019 In LOCKED, in_ready SHALL be high only for the locked input, and only while credit_cnt > 0; all other in_ready bits are zero.
REQ-020 out_valid SHALL equal in_valid and in_ready of the locked input, combinationally; out_sel SHALL equal the encoded olck_q index, and holds its last value while IDLE.
REQ-021 A transfer with in_tail set SHALL return the state to IDLE on the next edge, clear olck_q, and load ptr with the locked index.
REQ-022 A head-and-tail flit SHALL take one grant cycle plus one transfer cycle; back-to-back packets therefore incur one idle cycle on the link.
REQ-023 credit_cnt SHALL decrement by 1 on transfer, increment by 1 on credit_return, and be unchanged when both occur in the same cycle.
REQ-024 A credit_return while credit_cnt equals CREDIT_MAX with no transfer SHALL leave credit_cnt at CREDIT_MAX and set credit_err, which stays set until reset.
REQ-025 credit_cnt SHALL never underflow: in_ready being gated by credit_cnt > 0 guarantees this.
REQ-026 in_valid dropping mid-packet SHALL NOT release the lock; only a tail transfer releases it.

Reset
REQ-027 When reset is low: state IDLE, olck_q zero, ptr = NUM_IN-1 (so index 0 wins first), credit_cnt = CREDIT_MAX, credit_err zero, out_sel zero; out_valid and in_ready are therefore zero.
REQ-028 Reset asserted mid-packet SHALL abandon the lock immediately; no partial state survives.

Structure
REQ-029 The state enum and the credit-counter width function SHALL live in a shared router slice package.
REQ-030 The round-robin grant logic SHALL be one sub-module, router_rr_pick (request vector plus pointer in, one-hot grant out, purely combinational).

Verification
REQ-031 After reset, assert in_valid/in_head on inputs 0 and 2 -> olck_q = 0001 one cycle later, then 0100 after input 0's tail.
REQ-032 Lock input 1 with 4-flit packet, no credit_return -> four transfers, credit_cnt 4->0, in_ready[1] low while cnt = 0; one credit_return -> one more transfer allowed.
REQ-033 Simultaneous transfer and credit_return at credit_cnt = 2 -> credit_cnt stays 2.
REQ-034 credit_return at credit_cnt = 4 with no transfer -> credit_cnt stays 4, credit_err = 1 and remains set.
REQ-035 Input 3 valid without head while idle -> no grant; in_valid dropped mid-packet on locked input -> olck_q unchanged.
REQ-036 Reset low during LOCKED with credit_cnt = 1 -> olck_q = 0, credit_cnt = 4, in_ready = 0 asynchronously.
